circle_raster_engine: RTL and testbench

- Parametrised successor to the fixed 160x120 circle datapath and clear-screen scanner.
- One block holds the control FSM and the datapath for two jobs:
  - Mode 0: midpoint/Bresenham circle outline of any radius, with per-pixel clipping to the screen.
  - Mode 1: full-screen clear raster.
- Sits between the job source (random-value generator or user inputs) and the VGA adapter write port.
- Emits one pixel per valid/ready handshake, so a stalling frame-buffer writer is tolerated.

---
 rtl/circle_pkg.sv | 30 +++
 rtl/circle_octant_map.sv | 48 ++++
 rtl/circle_raster_engine.sv | 193 +++++++++++++++++++
 tb/tb_circle_raster_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types and width helpers for the circle/clear raster engine.
package circle_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StPlot,
      StStep,
      StClear,
      StFin
   } state_e;

   localparam logic MODE_OUTLINE = 1'b0;
   localparam logic MODE_CLEAR   = 1'b1;

   // Decision variable: 3-2r and its increments stay well inside r_w+4 signed bits.
   function automatic int unsigned dvar_width(input int unsigned r_w);
      return r_w + 4;
   endfunction

   // Signed candidate width: widest operand plus sign and carry, so no wrap-around.
   function automatic int unsigned coord_width(input int unsigned x_w, input int unsigned y_w,
                                               input int unsigned r_w);
      int unsigned m;
      m = (x_w > r_w) ? x_w : r_w;
      if (y_w > m) m = y_w;
      return m + 2;
   endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Maps (x, y, oct) around the centre to a signed screen candidate and flags it on-screen.
module circle_octant_map
   import circle_pkg::*;
#(
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned CW       = 10,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic [X_W-1:0]        xc,
   input  logic [Y_W-1:0]        yc,
   input  logic signed [CW-1:0]  x,
   input  logic signed [CW-1:0]  y,
   input  logic [2:0]            oct,
   output logic signed [CW-1:0]  cx,
   output logic signed [CW-1:0]  cy,
   output logic                  on_screen
);

   localparam logic signed [CW-1:0] SW = CW'(SCREEN_W);
   localparam logic signed [CW-1:0] SH = CW'(SCREEN_H);

   logic signed [CW-1:0] xcs;
   logic signed [CW-1:0] ycs;

   assign xcs = $signed({{(CW-X_W){1'b0}}, xc});
   assign ycs = $signed({{(CW-Y_W){1'b0}}, yc});

   always_comb begin
      cx = xcs;
      cy = ycs;
      unique case (oct)
         3'd0: begin cx = xcs + x; cy = ycs + y; end
         3'd1: begin cx = xcs - x; cy = ycs + y; end
         3'd2: begin cx = xcs + x; cy = ycs - y; end
         3'd3: begin cx = xcs - x; cy = ycs - y; end
         3'd4: begin cx = xcs + y; cy = ycs + x; end
         3'd5: begin cx = xcs - y; cy = ycs + x; end
         3'd6: begin cx = xcs + y; cy = ycs - x; end
         3'd7: begin cx = xcs - y; cy = ycs - x; end
         default: begin cx = xcs; cy = ycs; end
      endcase
   end

   assign on_screen = !cx[CW-1] && (cx < SW) && !cy[CW-1] && (cy < SH);

endmodule

// File: rtl/circle_raster_engine.sv
// Control FSM and datapath: midpoint circle outline with clipping, or full-screen clear,
// emitting one pixel per valid/ready handshake.
module circle_raster_engine
   import circle_pkg::*;
#(
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned R_W      = 8,
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120,
   parameter int unsigned COLOUR_W = 3
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic                mode,
   input  logic [X_W-1:0]      xc,
   input  logic [Y_W-1:0]      yc,
   input  logic [R_W-1:0]      radius,
   input  logic [COLOUR_W-1:0] colour,
   output logic [X_W-1:0]      pix_x,
   output logic [Y_W-1:0]      pix_y,
   output logic [COLOUR_W-1:0] pix_colour,
   output logic                pix_valid,
   input  logic                pix_ready,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CW = coord_width(X_W, Y_W, R_W);
   localparam int unsigned DW = dvar_width(R_W);
   localparam logic [X_W-1:0] XMAX = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0] YMAX = Y_W'(SCREEN_H - 1);

   state_e state_q, state_d;

   logic [X_W-1:0]      xc_q;
   logic [Y_W-1:0]      yc_q;
   logic [R_W-1:0]      radius_q;
   logic [COLOUR_W-1:0] colour_q;
   logic                accept;

   logic signed [CW-1:0] x_q, x_d, y_q, y_d;
   logic signed [CW-1:0] x_n, y_n;
   logic signed [DW-1:0] d_q, d_d;
   logic signed [DW-1:0] r_ext;
   logic [2:0]           oct_q, oct_d;
   logic [X_W-1:0]       scan_x_q, scan_x_d;
   logic [Y_W-1:0]       scan_y_q, scan_y_d;

   logic signed [CW-1:0] cand_x, cand_y;
   logic                 cand_on;

   assign r_ext      = $signed({{(DW-R_W){1'b0}}, radius_q});
   assign pix_colour = colour_q;

   circle_octant_map #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .CW       (CW),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_octant_map (
      .xc        (xc_q),
      .yc        (yc_q),
      .x         (x_q),
      .y         (y_q),
      .oct       (oct_q),
      .cx        (cand_x),
      .cy        (cand_y),
      .on_screen (cand_on)
   );

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      d_d       = d_q;
      oct_d     = oct_q;
      scan_x_d  = scan_x_q;
      scan_y_d  = scan_y_q;
      x_n       = x_q + CW'(1);
      y_n       = y_q;
      accept    = 1'b0;
      pix_valid = 1'b0;
      pix_x     = '0;
      pix_y     = '0;
      busy      = (state_q != StIdle);
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept = 1'b1;
               if (mode == MODE_CLEAR) begin
                  state_d  = StClear;
                  scan_x_d = '0;
                  scan_y_d = '0;
               end else begin
                  state_d = StInit;
               end
            end
         end

         StInit: begin
            x_d     = '0;
            y_d     = $signed({{(CW-R_W){1'b0}}, radius_q});
            d_d     = DW'(3) - (r_ext <<< 1);
            oct_d   = '0;
            state_d = StPlot;
         end

         StPlot: begin
            if (cand_on) begin
               pix_valid = 1'b1;
               pix_x     = X_W'(cand_x);
               pix_y     = Y_W'(cand_y);
            end
            // Clipped candidates advance unconditionally; visible ones wait for the handshake.
            if (!cand_on || pix_ready) begin
               oct_d = oct_q + 3'd1;
               if (oct_q == 3'd7) state_d = StStep;
            end
         end

         StStep: begin
            if (d_q[DW-1]) begin
               d_d = d_q + (DW'(x_q) <<< 2) + DW'(6);
            end else begin
               d_d = d_q + ((DW'(x_q) - DW'(y_q)) <<< 2) + DW'(10);
               y_n = y_q - CW'(1);
            end
            x_d     = x_n;
            y_d     = y_n;
            oct_d   = '0;
            state_d = (x_n <= y_n) ? StPlot : StFin;
         end

         StClear: begin
            pix_valid = 1'b1;
            pix_x     = scan_x_q;
            pix_y     = scan_y_q;
            if (pix_ready) begin
               if (scan_x_q == XMAX) begin
                  scan_x_d = '0;
                  if (scan_y_q == YMAX) state_d = StFin;
                  else scan_y_d = scan_y_q + Y_W'(1);
               end else begin
                  scan_x_d = scan_x_q + X_W'(1);
               end
            end
         end

         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q  <= StIdle;
         xc_q     <= '0;
         yc_q     <= '0;
         radius_q <= '0;
         colour_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         d_q      <= '0;
         oct_q    <= '0;
         scan_x_q <= '0;
         scan_y_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         d_q      <= d_d;
         oct_q    <= oct_d;
         scan_x_q <= scan_x_d;
         scan_y_q <= scan_y_d;
         if (accept) begin
            xc_q     <= xc;
            yc_q     <= yc;
            radius_q <= radius;
            colour_q <= colour;
         end
      end
   end

endmodule

// File: tb/tb_circle_raster_engine.sv
// Directed, table-driven bench for circle_raster_engine (default screen plus a 4x3 instance).
module tb_circle_raster_engine;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       resetn, start, mode, pix_ready;
   logic [7:0] xc, radius;
   logic [6:0] yc;
   logic [2:0] colour;
   logic [7:0] pix_x;
   logic [6:0] pix_y;
   logic [2:0] pix_colour;
   logic       pix_valid, busy, done;

   logic       s_resetn, s_start, s_mode, s_ready;
   logic [7:0] s_xc, s_radius;
   logic [6:0] s_yc;
   logic [2:0] s_colour;
   logic [7:0] s_pix_x;
   logic [6:0] s_pix_y;
   logic [2:0] s_pix_colour;
   logic       s_valid, s_busy, s_done;

   circle_raster_engine dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .mode       (mode),
      .xc         (xc),
      .yc         (yc),
      .radius     (radius),
      .colour     (colour),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_colour (pix_colour),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .done       (done)
   );

   circle_raster_engine #(
      .SCREEN_W (4),
      .SCREEN_H (3)
   ) dut_small (
      .clock      (clock),
      .resetn     (s_resetn),
      .start      (s_start),
      .mode       (s_mode),
      .xc         (s_xc),
      .yc         (s_yc),
      .radius     (s_radius),
      .colour     (s_colour),
      .pix_x      (s_pix_x),
      .pix_y      (s_pix_y),
      .pix_colour (s_pix_colour),
      .pix_valid  (s_valid),
      .pix_ready  (s_ready),
      .busy       (s_busy),
      .done       (s_done)
   );

   typedef struct {
      logic m;
      int   jx, jy, jr, jc;
      bit   bp;
      int   glitch;
      int   exp_n;
      int   fx, fy, lx, ly;
      int   exp_fv;
      int   exp_done;
   } job_t;

   int n_checks = 0;
   int n_fail   = 0;
   int got_x[$], got_y[$], exp_x[$], exp_y[$];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference: eight octant reflections of one (x, y) step, clipped to 160x120.
   task automatic add_pair(input int cx, input int cy, input int x, input int y);
      int px[8];
      int py[8];
      px = '{cx + x, cx - x, cx + x, cx - x, cx + y, cx - y, cx + y, cx - y};
      py = '{cy + y, cy + y, cy - y, cy - y, cy + x, cy + x, cy - x, cy - x};
      for (int i = 0; i < 8; i++) begin
         if (px[i] >= 0 && px[i] < 160 && py[i] >= 0 && py[i] < 120) begin
            exp_x.push_back(px[i]);
            exp_y.push_back(py[i]);
         end
      end
   endtask

   // Hand-derived midpoint (x, y) sequences for the radii used here.
   task automatic build_expected(input int cx, input int cy, input int r);
      exp_x.delete();
      exp_y.delete();
      case (r)
         0: add_pair(cx, cy, 0, 0);
         1: add_pair(cx, cy, 0, 1);
         2: begin add_pair(cx, cy, 0, 2); add_pair(cx, cy, 1, 2); end
         5: begin
            add_pair(cx, cy, 0, 5); add_pair(cx, cy, 1, 5);
            add_pair(cx, cy, 2, 5); add_pair(cx, cy, 3, 4);
         end
         default: ;
      endcase
   endtask

   task automatic run_job(input job_t j, output int first_valid, output int done_cyc,
                          output int n_done, output int colour_bad, output int stall_bad,
                          output int busy_bad);
      int cyc, tail, hx, hy, hc;
      bit stalled;
      got_x.delete();
      got_y.delete();
      first_valid = -1; done_cyc = -1; n_done = 0;
      colour_bad = 0; stall_bad = 0; busy_bad = 0;
      stalled = 1'b0; tail = 0; hx = 0; hy = 0; hc = 0;
      mode = j.m; xc = 8'(j.jx); yc = 7'(j.jy); radius = 8'(j.jr); colour = 3'(j.jc);
      start = 1'b1;
      pix_ready = 1'b1;
      tick();
      cyc = 1;
      while (cyc < 25000 && tail < 2) begin
         if (j.glitch == cyc) begin
            // Conflicting job request while busy; must be ignored.
            start = 1'b1; mode = 1'b1; xc = 8'd10; yc = 7'd10; radius = 8'd9;
            colour = ~3'(j.jc);
         end else begin
            start = 1'b0;
         end
         pix_ready = j.bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled && !(pix_valid && pix_x == 8'(hx) && pix_y == 7'(hy) &&
                          pix_colour == 3'(hc)))
            stall_bad++;
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc < 0 && !busy) busy_bad++;
         if (pix_valid && first_valid < 0) first_valid = cyc;
         if (pix_valid && pix_ready) begin
            got_x.push_back(int'(pix_x));
            got_y.push_back(int'(pix_y));
            if (pix_colour != 3'(j.jc)) colour_bad++;
         end
         stalled = pix_valid && !pix_ready;
         hx = int'(pix_x); hy = int'(pix_y); hc = int'(pix_colour);
         if (done_cyc >= 0) tail++;
         tick();
         cyc++;
      end
      start = 1'b0;
      pix_ready = 1'b1;
   endtask

   initial begin
      job_t jobs[8];
      int fv, dc, nd, cb, sb, bb, n;

      //          m     x    y    r  c  bp glitch n     first     last      fv done
      jobs[0] = '{1'b0, 80,  60,  2, 5, 1'b0, -1, 16,   80, 62,  78, 59,   2, 20};
      jobs[1] = '{1'b0, 80,  60,  5, 3, 1'b0, -1, 32,   80, 65,  76, 57,   2, 38};
      jobs[2] = '{1'b0, 80,  60,  5, 6, 1'b1, -1, 32,   80, 65,  76, 57,   2, -1};
      jobs[3] = '{1'b0, 0,   0,   1, 1, 1'b0, -1, 4,    0,  1,   1,  0,    2, 11};
      jobs[4] = '{1'b0, 159, 119, 1, 2, 1'b0, -1, 4,    159, 118, 158, 119, 4, 11};
      jobs[5] = '{1'b0, 80,  60,  0, 7, 1'b0, -1, 8,    80, 60,  80, 60,   2, 11};
      jobs[6] = '{1'b0, 80,  60,  2, 4, 1'b0, 5,  16,   80, 62,  78, 59,   2, 20};
      jobs[7] = '{1'b1, 33,  44, 17, 6, 1'b0, -1, 19200, 0, 0,   159, 119, 1, 19201};

      resetn = 1'b1; start = 1'b0; mode = 1'b0; pix_ready = 1'b0;
      xc = '0; yc = '0; radius = '0; colour = '0;
      s_resetn = 1'b1; s_start = 1'b0; s_mode = 1'b0; s_ready = 1'b0;
      s_xc = '0; s_yc = '0; s_radius = '0; s_colour = '0;
      tick();
      tick();
      check("reset pix_valid", int'(pix_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset pix_x", int'(pix_x), 0);
      check("reset pix_y", int'(pix_y), 0);
      check("reset pix_colour", int'(pix_colour), 0);
      check("small reset busy", int'(s_busy), 0);
      resetn = 1'b0;
      s_resetn = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_job(jobs[i], fv, dc, nd, cb, sb, bb);
         n = got_x.size();
         check($sformatf("job%0d pixel count", i), n, jobs[i].exp_n);
         check($sformatf("job%0d first valid cycle", i), fv, jobs[i].exp_fv);
         if (jobs[i].exp_done >= 0)
            check($sformatf("job%0d done cycle", i), dc, jobs[i].exp_done);
         check($sformatf("job%0d done pulses", i), nd, 1);
         check($sformatf("job%0d colour errors", i), cb, 0);
         check($sformatf("job%0d stall changes", i), sb, 0);
         check($sformatf("job%0d busy drops", i), bb, 0);
         check($sformatf("job%0d busy after", i), int'(busy), 0);
         check($sformatf("job%0d first pixel", i),
               (n > 0) ? got_x[0] * 256 + got_y[0] : -1, jobs[i].fx * 256 + jobs[i].fy);
         check($sformatf("job%0d last pixel", i),
               (n > 0) ? got_x[n-1] * 256 + got_y[n-1] : -1, jobs[i].lx * 256 + jobs[i].ly);
         if (jobs[i].m == 1'b0) begin
            build_expected(jobs[i].jx, jobs[i].jy, jobs[i].jr);
            check($sformatf("job%0d model count", i), n, exp_x.size());
            for (int k = 0; k < n && k < exp_x.size(); k++)
               check($sformatf("job%0d pixel %0d", i, k), got_x[k] * 256 + got_y[k],
                     exp_x[k] * 256 + exp_y[k]);
         end
      end

      // Reset during PLOT of a large circle, then a fresh job.
      mode = 1'b0; xc = 8'd80; yc = 7'd60; radius = 8'd30; colour = 3'd3;
      pix_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("midjob busy", int'(busy), 1);
      check("midjob valid", int'(pix_valid), 1);
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      check("midjob reset valid", int'(pix_valid), 0);
      check("midjob reset busy", int'(busy), 0);
      check("midjob reset done", int'(done), 0);
      check("midjob reset pix_x", int'(pix_x), 0);
      check("midjob reset colour", int'(pix_colour), 0);
      tick();
      check("idle stays idle", int'(busy), 0);
      run_job(jobs[0], fv, dc, nd, cb, sb, bb);
      check("post-reset count", got_x.size(), 16);
      check("post-reset first valid", fv, 2);
      check("post-reset done cycle", dc, 20);
      check("post-reset first pixel", (got_x.size() > 0) ? got_x[0] * 256 + got_y[0] : -1,
            80 * 256 + 62);

      // 4x3 clear with one stalled cycle.
      got_x.delete();
      got_y.delete();
      fv = -1; dc = -1; nd = 0; cb = 0;
      s_mode = 1'b1; s_colour = 3'd5; s_xc = 8'd2; s_radius = 8'd1; s_start = 1'b1;
      s_ready = 1'b1;
      tick();
      s_start = 1'b0;
      for (int cyc = 1; cyc < 60 && (dc < 0 || cyc <= dc + 1); cyc++) begin
         s_ready = (cyc != 3);
         if (s_valid && fv < 0) fv = cyc;
         if (s_done) begin
            nd++;
            if (dc < 0) dc = cyc;
         end
         if (s_valid && s_ready) begin
            got_x.push_back(int'(s_pix_x));
            got_y.push_back(int'(s_pix_y));
            if (s_pix_colour != 3'd5) cb++;
         end
         tick();
      end
      check("clear4x3 count", got_x.size(), 12);
      for (int k = 0; k < 12 && k < got_x.size(); k++)
         check($sformatf("clear4x3 pixel %0d", k), got_x[k] * 256 + got_y[k],
               (k % 4) * 256 + (k / 4));
      check("clear4x3 first valid", fv, 1);
      check("clear4x3 done cycle", dc, 14);
      check("clear4x3 done pulses", nd, 1);
      check("clear4x3 colour errors", cb, 0);
      check("clear4x3 busy after", int'(s_busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
